// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding RV64 load/store with programmable wait states.
// Optional DMEM_MISALIGN_CHECK_EN faults misaligned half/word/double accesses.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_n;
  logic [3:0]      cnt;
  logic            q_write;
  logic [2:0]      q_f3;
  logic [AW-1:0]   q_addr;
  logic [7:0]      mem [DEPTH] = '{default: 8'h00};

  logic            accept, fill;
  logic            c_write, c_err, c_mis;
  logic            w_err, w_mis;
  logic [2:0]      c_f3;
  logic [AW-1:0]   c_addr, w_addr;
  logic [63:0]     raw, rdata_n;
  logic [7:0]      wmask;
  logic            unused_addr;

  assign unused_addr = ^req_addr[63:AW];
  assign w_addr      = req_addr[AW-1:0];
  assign accept      = (state == IDLE) && req_valid;

  // With zero latency the result is captured at the accepting edge itself.
  assign fill = (LATENCY == 0) ? accept
                               : ((state == WAIT) && (cnt == 4'd1));

  assign c_write = (state == IDLE) ? req_write  : q_write;
  assign c_f3    = (state == IDLE) ? req_funct3 : q_f3;
  assign c_addr  = (state == IDLE) ? w_addr     : q_addr;

`ifdef DMEM_MISALIGN_CHECK_EN
  function automatic logic misaligned(input logic [1:0] sz,
                                      input logic [2:0] a);
    case (sz)
      2'd1:    return a[0];
      2'd2:    return |a[1:0];
      2'd3:    return |a;
      default: return 1'b0;
    endcase
  endfunction
  assign c_mis = misaligned(c_f3[1:0], c_addr[2:0]);
  assign w_mis = misaligned(req_funct3[1:0], w_addr[2:0]);
`else
  assign c_mis = 1'b0;
  assign w_mis = 1'b0;
`endif

  assign c_err = (c_f3 == 3'b111) || c_mis;
  assign w_err = (req_funct3 == 3'b111) || w_mis;

  // Bytes wrap modulo DEPTH through the AW-bit index arithmetic.
  always_comb begin
    raw = '0;
    for (int k = 0; k < 8; k++)
      raw[8*k +: 8] = mem[c_addr + AW'(k)];
  end

  always_comb begin
    rdata_n = '0;
    case (c_f3)
      3'b000:  rdata_n = {{56{raw[7]}},  raw[7:0]};
      3'b001:  rdata_n = {{48{raw[15]}}, raw[15:0]};
      3'b010:  rdata_n = {{32{raw[31]}}, raw[31:0]};
      3'b011:  rdata_n = raw;
      3'b100:  rdata_n = {56'd0, raw[7:0]};
      3'b101:  rdata_n = {48'd0, raw[15:0]};
      3'b110:  rdata_n = {32'd0, raw[31:0]};
      default: rdata_n = '0;
    endcase
    if (c_write || c_err)
      rdata_n = '0;
  end

  always_comb begin
    wmask = 8'h00;
    case (req_funct3[1:0])
      2'd0:    wmask = 8'h01;
      2'd1:    wmask = 8'h03;
      2'd2:    wmask = 8'h0f;
      default: wmask = 8'hff;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && req_write && !w_err && !reset)
      for (int k = 0; k < 8; k++)
        if (wmask[k])
          mem[w_addr + AW'(k)] <= req_wdata[8*k +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_valid)
                 state_n = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_n = RESP;
      RESP:    if (resp_ready)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      q_write    <= 1'b0;
      q_f3       <= '0;
      q_addr     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= 4'(LATENCY);
        q_write <= req_write;
        q_f3    <= req_funct3;
        q_addr  <= w_addr;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (fill) begin
        resp_rdata <= rdata_n;
        resp_err   <= c_err;
      end
    end
  end

endmodule
